wire_resolve_pipe: RTL

WIRE_RESOLVE_PIPE -- requirements
Module: wire_resolve_pipe

---
 rtl/wire_resolve_pkg.sv | 48 ++++
 rtl/wire_resolve_fifo.sv | 49 ++++
 rtl/wire_resolve_pipe.sv | 108 ++++++++++
 3 files changed

// File: rtl/wire_resolve_pkg.sv
// Shared types and the per-bit resolution rule for wire_resolve_pipe.
//   mode_e      : channel net type (TRI, WOR, WAND, TRIREG)
//   res_t       : resolved bit {x, known, val}
//   resolve_bit : resolves one bit from driver summary flags and the hold bit
package wire_resolve_pkg;

  typedef enum logic [1:0] {
    TRI    = 2'b00,
    WOR    = 2'b01,
    WAND   = 2'b10,
    TRIREG = 2'b11
  } mode_e;

  typedef struct packed {
    logic x;      // driver disagreement
    logic known;  // 1: val is 0/1; 0: X or Z
    logic val;    // 0 whenever not known
  } res_t;

  // any_en: some driver enabled; any1/any0: some enabled driver drives 1/0.
  function automatic res_t resolve_bit(input mode_e mode, input logic any_en,
                                       input logic any1, input logic any0,
                                       input logic hold_val, input logic hold_known);
    res_t r;
    r = '0;
    if (!any_en) begin
      // Undriven: Z, except TRIREG which keeps the last resolved charge.
      if (mode == TRIREG) begin
        r.val   = hold_val;
        r.known = hold_known;
      end
    end else begin
      case (mode)
        WOR:  begin r.val = any1;  r.known = 1'b1; end
        WAND: begin r.val = !any0; r.known = 1'b1; end
        default: begin
          if (any1 && any0) r.x = 1'b1;
          else begin
            r.val   = any1;
            r.known = 1'b1;
          end
        end
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/wire_resolve_fifo.sv
// Output buffer for wire_resolve_pipe: DEPTH-entry FIFO of DW-bit words.
//   push/push_data : write (caller guarantees not full)
//   pop            : drop head (caller guarantees not empty)
//   head/head_vld  : head word (forced to 0 while empty) and its valid
//   fill           : number of stored words
module wire_resolve_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [DW-1:0]              head,
  output logic                       head_vld,
  output logic [$clog2(DEPTH+1)-1:0] fill
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      fill <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible until fill says so.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_data;
  end

  assign head_vld = (fill != '0);
  assign head     = head_vld ? mem[rptr] : '0;

endmodule

// File: rtl/wire_resolve_pipe.sv
// Multi-driver wire resolution with a buffered valid/ready output.
// Each accepted beat resolves NCH channels of WIDTH bits from NDRV drivers
// (TRI / WOR / WAND / TRIREG per channel) and queues the result.
//   in_valid/in_ready            : input handshake
//   in_mode  [NCH*2]             : per-channel mode
//   drv_val/drv_en [NCH*NDRV*WIDTH] : driver values / per-bit enables,
//                                  bit index (ch*NDRV+drv)*WIDTH+bit
//   out_valid/out_ready          : output handshake
//   out_val/out_known [NCH*WIDTH], out_conflict [NCH], fill
// Optional: define WIRE_RESOLVE_CONFLICT_CNT_EN to add conflict_cnt
// [NCH*16], saturating per-channel counts of accepted conflicting beats.
module wire_resolve_pipe
  import wire_resolve_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NDRV  = 3,
  parameter int NCH   = 2,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NCH*2-1:0]            in_mode,
  input  logic [NCH*NDRV*WIDTH-1:0]   drv_val,
  input  logic [NCH*NDRV*WIDTH-1:0]   drv_en,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NCH*WIDTH-1:0]        out_val,
  output logic [NCH*WIDTH-1:0]        out_known,
  output logic [NCH-1:0]              out_conflict,
  output logic [$clog2(DEPTH+1)-1:0]  fill
`ifdef WIRE_RESOLVE_CONFLICT_CNT_EN
 ,output logic [NCH*16-1:0]           conflict_cnt
`endif
);
  localparam int FW = $clog2(DEPTH+1);
  localparam int DW = NCH*(2*WIDTH+1);

  logic                   started;
  logic                   accept, pop;
  logic [NCH*WIDTH-1:0]   res_val, res_known, res_x;
  logic [NCH-1:0]         res_conf;
  logic [NCH*WIDTH-1:0]   hold_val, hold_known;
  logic [DW-1:0]          head;

  // in_ready stays low through reset and rises on the first edge after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) started <= 1'b0;
    else        started <= 1'b1;
  end

  assign in_ready = started && (fill != FW'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      logic [NDRV-1:0] v, e;
      res_t r;
      for (genvar d = 0; d < NDRV; d++) begin : g_drv
        assign v[d] = drv_val[(c*NDRV+d)*WIDTH+b];
        assign e[d] = drv_en[(c*NDRV+d)*WIDTH+b];
      end
      assign r = resolve_bit(mode_e'(in_mode[2*c +: 2]), |e, |(v & e), |(~v & e),
                             hold_val[c*WIDTH+b], hold_known[c*WIDTH+b]);
      assign res_val[c*WIDTH+b]   = r.val;
      assign res_known[c*WIDTH+b] = r.known;
      assign res_x[c*WIDTH+b]     = r.x;
    end
    assign res_conf[c] = |res_x[c*WIDTH +: WIDTH];

`ifdef WIRE_RESOLVE_CONFLICT_CNT_EN
    logic [15:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                     cnt <= '0;
      else if (accept && res_conf[c] && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
    assign conflict_cnt[c*16 +: 16] = cnt;
`endif
  end

  // Hold registers track the last resolved value in every mode; only
  // TRIREG reads them back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_val   <= '0;
      hold_known <= '0;
    end else if (accept) begin
      hold_val   <= res_val;
      hold_known <= res_known;
    end
  end

  wire_resolve_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data ({res_conf, res_known, res_val}),
    .pop       (pop),
    .head      (head),
    .head_vld  (out_valid),
    .fill      (fill)
  );

  assign {out_conflict, out_known, out_val} = head;

endmodule
